switch_debounce_sampler: RTL and testbench



---
 rtl/switch_debounce_sampler.sv | 132 +++++++++++++
 tb/tb_switch_debounce_sampler.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/switch_debounce_sampler.sv
// Switch input stage: two-flop synchronizer, per-bit debounce counters and a
// coalescing valid/ready presenter feeding the Walsh transform datapath.
module switch_debounce_sampler #(
    parameter int unsigned WIDTH           = 8,
    parameter int unsigned DEBOUNCE_CYCLES = 500000,  // must be >= 2
    parameter int unsigned CNT_W           = 19       // must hold DEBOUNCE_CYCLES-1
) (
    input  logic             iCLK_50,
    input  logic             iRST_N,
    input  logic [WIDTH-1:0] iSW,
    input  logic             iREADY,
    output logic [WIDTH-1:0] oWORD,
    output logic             oVALID,
    output logic [WIDTH-1:0] oSTABLE,
    output logic             oOVERRUN
);

    localparam logic [CNT_W-1:0] CntMax = CNT_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic {
        StIdle,
        StPresent
    } state_e;

    logic [WIDTH-1:0]            sync1_q;
    logic [WIDTH-1:0]            sync2_q;
    logic [WIDTH-1:0]            db_q;
    logic [WIDTH-1:0]            db_d;
    logic [WIDTH-1:0][CNT_W-1:0] cnt_q;
    logic [WIDTH-1:0][CNT_W-1:0] cnt_d;
    logic [WIDTH-1:0]            upd_bits;
    logic                        upd_event;

    state_e                      state_q;
    state_e                      state_d;
    logic [WIDTH-1:0]            word_q;
    logic [WIDTH-1:0]            word_d;
    logic                        dirty_q;
    logic                        dirty_d;
    logic                        overrun_q;
    logic                        overrun_d;

    always_ff @(posedge iCLK_50 or negedge iRST_N) begin
        if (!iRST_N) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= iSW;
            sync2_q <= sync1_q;
        end
    end

    // A bit only flips after DEBOUNCE_CYCLES consecutive mismatching edges.
    always_comb begin
        db_d     = db_q;
        cnt_d    = cnt_q;
        upd_bits = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (sync2_q[i] == db_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == CntMax) begin
                db_d[i]     = sync2_q[i];
                cnt_d[i]    = '0;
                upd_bits[i] = 1'b1;
            end else begin
                cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end
        end
    end

    assign upd_event = |upd_bits;

    always_ff @(posedge iCLK_50 or negedge iRST_N) begin
        if (!iRST_N) begin
            db_q  <= '0;
            cnt_q <= '0;
        end else begin
            db_q  <= db_d;
            cnt_q <= cnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        word_d    = word_q;
        dirty_d   = dirty_q;
        overrun_d = overrun_q;
        case (state_q)
            StIdle: begin
                if (dirty_q) begin
                    // Load the value after this edge's update so the newest word wins.
                    word_d  = db_d;
                    dirty_d = 1'b0;
                    state_d = StPresent;
                end
            end
            StPresent: begin
                if (upd_event && dirty_q) begin
                    overrun_d = 1'b1;
                end
                if (iREADY) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
        if (upd_event) begin
            dirty_d = 1'b1;
        end
    end

    // dirty resets high so the reset word is presented once.
    always_ff @(posedge iCLK_50 or negedge iRST_N) begin
        if (!iRST_N) begin
            state_q   <= StIdle;
            word_q    <= '0;
            dirty_q   <= 1'b1;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            word_q    <= word_d;
            dirty_q   <= dirty_d;
            overrun_q <= overrun_d;
        end
    end

    assign oWORD    = word_q;
    assign oVALID   = (state_q == StPresent);
    assign oSTABLE  = db_q;
    assign oOVERRUN = overrun_q;

endmodule

// File: tb/tb_switch_debounce_sampler.sv
// Self-checking bench: directed scenarios plus randomized switch/ready traffic,
// all compared every cycle against a behavioural model.
module tb_switch_debounce_sampler;

    localparam int unsigned WIDTH = 8;
    localparam int unsigned DB    = 4;

    logic             clk   = 1'b0;
    logic             rst_n = 1'b1;
    logic [WIDTH-1:0] sw    = '0;
    logic             ready = 1'b0;
    logic [WIDTH-1:0] word;
    logic             valid;
    logic [WIDTH-1:0] stable;
    logic             overrun;

    int n_checks = 0;
    int n_errors = 0;

    switch_debounce_sampler #(
        .WIDTH          (WIDTH),
        .DEBOUNCE_CYCLES(DB),
        .CNT_W          (3)
    ) dut (
        .iCLK_50 (clk),
        .iRST_N  (rst_n),
        .iSW     (sw),
        .iREADY  (ready),
        .oWORD   (word),
        .oVALID  (valid),
        .oSTABLE (stable),
        .oOVERRUN(overrun)
    );

    always #5 clk = ~clk;

    // Model: a bit flips once its last DB synchronized samples all disagree with it.
    logic [WIDTH-1:0] m_s1, m_s2, m_db, m_word;
    logic [WIDTH-1:0] m_hist [DB];
    logic             m_valid, m_dirty, m_ovr;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_s1 = '0; m_s2 = '0; m_db = '0; m_word = '0;
        for (int k = 0; k < DB; k++) m_hist[k] = '0;
        m_valid = 1'b0; m_dirty = 1'b1; m_ovr = 1'b0;
    endtask

    task automatic model_step();
        logic [WIDTH-1:0] upd;
        logic [WIDTH-1:0] new_db;
        logic             ev;
        for (int k = DB - 1; k > 0; k--) m_hist[k] = m_hist[k-1];
        m_hist[0] = m_s2;
        upd = '1;
        for (int k = 0; k < DB; k++) upd &= (m_hist[k] ^ m_db);
        ev     = |upd;
        new_db = m_db ^ upd;
        if (!m_valid) begin
            if (m_dirty) begin
                m_word  = new_db;
                m_valid = 1'b1;
                m_dirty = ev;
            end else if (ev) begin
                m_dirty = 1'b1;
            end
        end else begin
            if (ev && m_dirty) m_ovr = 1'b1;
            if (ev) m_dirty = 1'b1;
            if (ready) m_valid = 1'b0;
        end
        m_db = new_db;
        m_s2 = m_s1;
        m_s1 = sw;
    endtask

    task automatic cycle();
        @(posedge clk);
        if (rst_n) model_step();
        else model_reset();
        @(negedge clk);
        check_eq("valid", 32'(valid), 32'(m_valid));
        check_eq("stable", 32'(stable), 32'(m_db));
        check_eq("overrun", 32'(overrun), 32'(m_ovr));
        if (m_valid) check_eq("word", 32'(word), 32'(m_word));
    endtask

    task automatic run(input int n);
        for (int c = 0; c < n; c++) cycle();
    endtask

    task automatic check_cleared(input string tag);
        check_eq({tag, "_valid"}, 32'(valid), 32'd0);
        check_eq({tag, "_word"}, 32'(word), 32'd0);
        check_eq({tag, "_stable"}, 32'(stable), 32'd0);
        check_eq({tag, "_overrun"}, 32'(overrun), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        model_reset();
        // 1. Reset with switches high
        sw = 8'hFF;
        #1 rst_n = 1'b0;
        #1 check_cleared("rst_hold");
        run(3);
        check_cleared("rst_hold2");
        rst_n = 1'b0;
        rst_n = 1'b1;
        ready = 1'b1;
        cycle();
        check_eq("t1_first_valid", 32'(valid), 32'd1);
        check_eq("t1_first_word", 32'(word), 32'h00);
        run(4);
        check_eq("t1_stable_e5", 32'(stable), 32'h00);
        cycle();
        check_eq("t1_stable_e6", 32'(stable), 32'hFF);
        cycle();
        check_eq("t1_second_valid", 32'(valid), 32'd1);
        check_eq("t1_second_word", 32'(word), 32'hFF);
        run(3);

        // 2. Clean toggle of two bits from 0x00
        sw = 8'h00;
        run(12);
        sw = 8'h81;
        run(5);
        check_eq("t2_stable_early", 32'(stable), 32'h00);
        cycle();
        check_eq("t2_stable", 32'(stable), 32'h81);
        check_eq("t2_valid_early", 32'(valid), 32'd0);
        cycle();
        check_eq("t2_valid", 32'(valid), 32'd1);
        check_eq("t2_word", 32'(word), 32'h81);
        cycle();
        check_eq("t2_valid_drop", 32'(valid), 32'd0);
        check_eq("t2_no_overrun", 32'(overrun), 32'd0);

        // 3. Bounce rejection on bit 3
        sw = 8'h00;
        run(12);
        for (int w = 1; w <= 3; w++) begin
            sw = 8'h08;
            run(w);
            sw = 8'h00;
            run(6);
            check_eq("t3_bounce_stable", 32'(stable), 32'h00);
        end
        sw = 8'h08;
        run(10);
        check_eq("t3_stable", 32'(stable), 32'h08);

        // 5. Update event on the same edge as acceptance
        ready = 1'b0;
        sw = 8'h18;
        run(8);
        check_eq("t5_held", 32'(word), 32'h18);
        sw = 8'h38;
        run(5);
        ready = 1'b1;
        cycle();
        check_eq("t5_gap_valid", 32'(valid), 32'd0);
        check_eq("t5_gap_stable", 32'(stable), 32'h38);
        ready = 1'b0;
        cycle();
        check_eq("t5_new_valid", 32'(valid), 32'd1);
        check_eq("t5_new_word", 32'(word), 32'h38);
        check_eq("t5_no_overrun", 32'(overrun), 32'd0);
        ready = 1'b1;
        cycle();
        ready = 1'b0;
        run(2);

        // 4. Backpressure and coalescing
        sw = 8'h01;
        run(10);
        sw = 8'h03;
        run(10);
        check_eq("t4_overrun_before", 32'(overrun), 32'd0);
        sw = 8'h07;
        run(10);
        check_eq("t4_hold_word", 32'(word), 32'h01);
        check_eq("t4_overrun", 32'(overrun), 32'd1);
        ready = 1'b1;
        cycle();
        ready = 1'b0;
        check_eq("t4_accept_gap", 32'(valid), 32'd0);
        cycle();
        check_eq("t4_next_valid", 32'(valid), 32'd1);
        check_eq("t4_next_word", 32'(word), 32'h07);

        // 6. Reset while a word is held and a counter is mid-count
        sw = 8'h5A;
        run(3);
        #2 rst_n = 1'b0;
        #1 check_cleared("t6_rst");
        run(2);
        rst_n = 1'b1;
        ready = 1'b1;
        cycle();
        check_eq("t6_zero_valid", 32'(valid), 32'd1);
        check_eq("t6_zero_word", 32'(word), 32'h00);
        run(5);
        check_eq("t6_stable", 32'(stable), 32'h5A);
        cycle();
        check_eq("t6_word_valid", 32'(valid), 32'd1);
        check_eq("t6_word", 32'(word), 32'h5A);

        // Randomized traffic: bounces, multi-bit changes and random backpressure
        for (int it = 0; it < 400; it++) begin
            if ($urandom_range(0, 3) == 0) begin
                logic [WIDTH-1:0] base;
                base = sw;
                sw = base ^ WIDTH'(1 << $urandom_range(0, WIDTH - 1));
                for (int c = 0; c < int'($urandom_range(1, 3)); c++) begin
                    ready = ($urandom_range(0, 2) != 0);
                    cycle();
                end
                sw = base;
            end else begin
                sw = WIDTH'($urandom);
            end
            for (int c = 0; c < int'($urandom_range(1, 12)); c++) begin
                ready = ($urandom_range(0, 2) != 0);
                cycle();
            end
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
